// File: rtl/calc_pkg.sv
// Shared definitions for the calculator controller: key codes, ALU op codes,
// controller states and key classification helpers.
package calc_pkg;

    localparam int unsigned MAX_VAL_DEF = 9999;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_NOP = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPA,
        S_OPW,
        S_OPB,
        S_EXEC,
        S_SHOW,
        S_ERR
    } state_e;

    typedef enum logic [2:0] {
        K_NONE,
        K_DIGIT,
        K_OPER,
        K_EQ,
        K_CLR
    } key_cls_e;

    function automatic key_cls_e key_class(input logic [3:0] k);
        if (k <= 4'd9) return K_DIGIT;
        case (k)
            KEY_ADD, KEY_SUB, KEY_MUL: return K_OPER;
            KEY_EQ:                    return K_EQ;
            KEY_CLR:                   return K_CLR;
            KEY_NOP:                   return K_NONE;
            default:                   return K_NONE;
        endcase
    endfunction

    function automatic op_e key_op(input logic [3:0] k);
        case (k)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// Keypad, shared-ALU and display signals of the calculator controller.
interface calc_ctrl_if #(
    parameter int unsigned W = 16
);
    logic         key_vld;
    logic [3:0]   key_code;
    logic         key_rdy;
    logic         alu_start;
    logic [1:0]   alu_op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         alu_done;
    logic [W-1:0] alu_res;
    logic         alu_err;
    logic [W-1:0] disp;
    logic         err;

    modport master (
        input  key_vld, key_code, alu_done, alu_res, alu_err,
        output key_rdy, alu_start, alu_op, opa, opb, disp, err
    );

    modport slave (
        output key_vld, key_code, alu_done, alu_res, alu_err,
        input  key_rdy, alu_start, alu_op, opa, opb, disp, err
    );
endinterface

// File: rtl/calc_ctrl_digit_acc.sv
// Decimal entry accumulator: load a first digit, shift in further digits
// while the value stays within MAX_VAL, or clear.
module digit_acc
    import calc_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned MAX_VAL = MAX_VAL_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] entry_o
);

    logic [W-1:0] entry_q, entry_d;
    logic [W+3:0] shifted;

    always_comb begin
        shifted = ({4'd0, entry_q} * (W+4)'(10)) + (W+4)'(digit_i);
        entry_d = entry_q;
        if (clr_i) begin
            entry_d = '0;
        end else if (load_i) begin
            entry_d = W'(digit_i);
        end else if (shift_i && (shifted <= (W+4)'(MAX_VAL))) begin
            // A digit that would overflow MAX_VAL is dropped, value kept.
            entry_d = shifted[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) entry_q <= '0;
        else        entry_q <= entry_d;
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator key-sequence controller: collects operands from a keypad,
// drives a shared multi-cycle ALU with chaining, timeout and error handling.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned MAX_VAL = MAX_VAL_DEF,
    parameter int unsigned TMO     = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    calc_ctrl_if.master bus
);

    localparam int unsigned TW = $clog2(TMO + 1);

    logic [1:0]   rst_sync_q;
    logic         rst_s_n;

    state_e       state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [W-1:0] opa_q, opa_d;
    logic [W-1:0] opb_q, opb_d;
    logic [W-1:0] res_q, res_d;
    op_e          op_q, op_d;
    op_e          pend_op_q, pend_op_d;
    logic         pend_vld_q, pend_vld_d;
    logic         start_q, start_d;

    logic         acc_clr, acc_load, acc_shift;
    logic [W-1:0] entry;
    logic         key_acc;
    key_cls_e     kcls;
    op_e          kop;
    logic         res_ok;
    logic [W-1:0] disp_d;

    // Assertion is immediate; release is delayed two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_s_n = rst_sync_q[1];

    digit_acc #(
        .W       (W),
        .MAX_VAL (MAX_VAL)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_s_n),
        .clr_i   (acc_clr),
        .load_i  (acc_load),
        .shift_i (acc_shift),
        .digit_i (bus.key_code),
        .entry_o (entry)
    );

    always_comb begin
        state_d    = state_q;
        tmr_d      = '0;
        opa_d      = opa_q;
        opb_d      = opb_q;
        res_d      = res_q;
        op_d       = op_q;
        pend_op_d  = pend_op_q;
        pend_vld_d = pend_vld_q;
        acc_clr    = 1'b0;
        acc_load   = 1'b0;
        acc_shift  = 1'b0;
        key_acc    = bus.key_vld && (state_q != S_EXEC);
        kcls       = key_class(bus.key_code);
        kop        = key_op(bus.key_code);
        res_ok     = !bus.alu_err && (bus.alu_res <= W'(MAX_VAL));

        if (state_q == S_EXEC) begin
            if (bus.alu_done) begin
                if (!res_ok) begin
                    state_d = S_ERR;
                end else if (pend_vld_q) begin
                    opa_d      = bus.alu_res;
                    op_d       = pend_op_q;
                    pend_vld_d = 1'b0;
                    state_d    = S_OPW;
                end else begin
                    res_d   = bus.alu_res;
                    state_d = S_SHOW;
                end
            end else if (tmr_q == TW'(TMO - 1)) begin
                state_d = S_ERR;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end else if (key_acc) begin
            if (kcls == K_CLR) begin
                state_d    = S_IDLE;
                acc_clr    = 1'b1;
                opa_d      = '0;
                opb_d      = '0;
                res_d      = '0;
                op_d       = OP_ADD;
                pend_op_d  = OP_ADD;
                pend_vld_d = 1'b0;
            end else if (state_q != S_ERR) begin
                case (kcls)
                    K_DIGIT: begin
                        case (state_q)
                            S_IDLE, S_SHOW: begin acc_load = 1'b1; state_d = S_OPA; end
                            S_OPW:          begin acc_load = 1'b1; state_d = S_OPB; end
                            default:        acc_shift = 1'b1;
                        endcase
                    end
                    K_OPER: begin
                        case (state_q)
                            S_IDLE: begin opa_d = '0;    op_d = kop; state_d = S_OPW; end
                            S_OPA:  begin opa_d = entry; op_d = kop; state_d = S_OPW; end
                            S_SHOW: begin opa_d = res_q; op_d = kop; state_d = S_OPW; end
                            S_OPW:  op_d = kop;
                            default: begin
                                // Run the old op now; the new one waits as the chain op.
                                opb_d      = entry;
                                pend_op_d  = kop;
                                pend_vld_d = 1'b1;
                                state_d    = S_EXEC;
                            end
                        endcase
                    end
                    K_EQ: begin
                        case (state_q)
                            S_OPB: begin opb_d = entry; pend_vld_d = 1'b0; state_d = S_EXEC; end
                            S_OPW: begin opb_d = opa_q; pend_vld_d = 1'b0; state_d = S_EXEC; end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end

        start_d = (state_d == S_EXEC) && (state_q != S_EXEC);
    end

    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            res_q      <= '0;
            op_q       <= OP_ADD;
            pend_op_q  <= OP_ADD;
            pend_vld_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            res_q      <= res_d;
            op_q       <= op_d;
            pend_op_q  <= pend_op_d;
            pend_vld_q <= pend_vld_d;
            start_q    <= start_d;
        end
    end

    always_comb begin
        disp_d = '0;
        case (state_q)
            S_OPA, S_OPB, S_EXEC: disp_d = entry;
            S_OPW:                disp_d = opa_q;
            S_SHOW:               disp_d = res_q;
            default:              disp_d = '0;
        endcase
    end

    assign bus.key_rdy   = (state_q != S_EXEC);
    assign bus.alu_start = start_q;
    assign bus.alu_op    = op_q;
    assign bus.opa       = opa_q;
    assign bus.opb       = opb_q;
    assign bus.disp      = disp_d;
    assign bus.err       = (state_q == S_ERR);

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: directed scenarios plus random operator chains checked
// against left-to-right integer evaluation.
module tb_calc_ctrl;
    import calc_pkg::*;

    localparam int unsigned W    = 16;
    localparam int unsigned MAXV = 9999;
    localparam int unsigned TMO  = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    calc_ctrl_if #(.W(W)) bus ();

    calc_ctrl #(
        .W       (W),
        .MAX_VAL (MAXV),
        .TMO     (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total  = 0;
    int bad    = 0;
    int starts = 0;

    always @(negedge clk) if (bus.alu_start === 1'b1) starts++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_vld  = 1'b1;
        bus.key_code = k;
        @(negedge clk);
        bus.key_vld  = 1'b0;
        bus.key_code = KEY_NOP;
    endtask

    task automatic type_num(input int n);
        int d[$];
        int v = n;
        do begin
            d.push_front(v % 10);
            v = v / 10;
        end while (v > 0);
        foreach (d[i]) press(4'(d[i]));
    endtask

    function automatic longint alu_true(input longint a, input longint b, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            default: return a * b;
        endcase
    endfunction

    function automatic logic [3:0] opkey(input logic [1:0] op);
        return 4'hA + {2'b00, op};
    endfunction

    // Behaves as the shared ALU: waits for the start, checks operands, answers after lat cycles.
    task automatic serve(input longint ea, input longint eb, input logic [1:0] eop,
                         input int lat, input string tag);
        int waited = 0;
        longint r;
        while (bus.alu_start !== 1'b1 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_start"}, bus.alu_start, 1);
        chk({tag, "_rdy"},   bus.key_rdy, 0);
        chk({tag, "_opa"},   bus.opa, ea[31:0]);
        chk({tag, "_opb"},   bus.opb, eb[31:0]);
        chk({tag, "_op"},    bus.alu_op, eop);
        r = alu_true(ea, eb, eop);
        @(negedge clk);
        chk({tag, "_pulse"}, bus.alu_start, 0);
        repeat (lat - 1) @(negedge clk);
        chk({tag, "_hold_op"}, bus.alu_op, eop);
        bus.alu_done = 1'b1;
        bus.alu_res  = W'(r);
        bus.alu_err  = (r < 0) || (r > 65535);
        @(negedge clk);
        bus.alu_done = 1'b0;
        bus.alu_res  = '0;
        bus.alu_err  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int early;
        int nops;
        int vals[4];
        logic [1:0] ops[3];
        longint acc;
        bit dead;

        bus.key_vld  = 1'b0;
        bus.key_code = KEY_NOP;
        bus.alu_done = 1'b0;
        bus.alu_res  = '0;
        bus.alu_err  = 1'b0;

        // Reset values while reset is held.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rdy",   bus.key_rdy, 1);
        chk("rst_start", bus.alu_start, 0);
        chk("rst_op",    bus.alu_op, 0);
        chk("rst_opa",   bus.opa, 0);
        chk("rst_opb",   bus.opb, 0);
        chk("rst_disp",  bus.disp, 0);
        chk("rst_err",   bus.err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 12 + 3 =
        s0 = starts;
        press(KEY_CLR);
        press(4'd1); press(4'd2);
        chk("t37_entry", bus.disp, 12);
        press(KEY_ADD);
        chk("t37_opw_disp", bus.disp, 12);
        press(4'd3);
        chk("t37_opb_disp", bus.disp, 3);
        press(KEY_EQ);
        serve(12, 3, 2'b00, 3, "t37");
        chk("t37_disp", bus.disp, 15);
        chk("t37_err", bus.err, 0);
        chk("t37_rdy", bus.key_rdy, 1);
        chk("t37_starts", starts - s0, 1);

        // Saturating entry.
        press(KEY_CLR);
        repeat (4) press(4'd9);
        chk("t38_4dig", bus.disp, 9999);
        s0 = starts;
        press(4'd9);
        chk("t38_5dig", bus.disp, 9999);
        press(KEY_EQ);
        repeat (2) @(negedge clk);
        chk("t38_eq_ignored", starts - s0, 0);
        chk("t38_eq_disp", bus.disp, 9999);
        press(KEY_SUB);
        chk("t38_still_opa", bus.disp, 9999);
        chk("t38_no_start", starts - s0, 0);
        press(KEY_CLR);
        type_num(1000);
        press(4'd0);
        chk("t38_1000_drop", bus.disp, 1000);

        // 5 + 3 * 2 = chained.
        s0 = starts;
        press(KEY_CLR);
        press(4'd5); press(KEY_ADD); press(4'd3); press(KEY_MUL);
        serve(5, 3, 2'b00, 2, "t39a");
        chk("t39_chain_disp", bus.disp, 8);
        press(4'd2); press(KEY_EQ);
        serve(8, 2, 2'b10, 1, "t39b");
        chk("t39_disp", bus.disp, 16);
        chk("t39_starts", starts - s0, 2);

        // 7 - 8 = underflow.
        press(KEY_CLR);
        press(4'd7); press(KEY_SUB); press(4'd8); press(KEY_EQ);
        serve(7, 8, 2'b01, 2, "t40");
        chk("t40_err", bus.err, 1);
        chk("t40_disp", bus.disp, 0);
        chk("t40_rdy", bus.key_rdy, 1);
        press(4'd5);
        chk("t40_dig_err", bus.err, 1);
        chk("t40_dig_disp", bus.disp, 0);
        press(KEY_CLR);
        chk("t40_clr_err", bus.err, 0);
        chk("t40_clr_disp", bus.disp, 0);
        press(4'd3);
        chk("t40_after_clr", bus.disp, 3);

        // ALU never answers.
        press(KEY_CLR);
        press(4'd1); press(KEY_ADD); press(4'd1); press(KEY_EQ);
        early = 0;
        for (int i = 0; i < 4 && bus.alu_start !== 1'b1; i++) @(negedge clk);
        chk("t41_start", bus.alu_start, 1);
        for (int i = 1; i < int'(TMO); i++) begin
            @(negedge clk);
            if (bus.err !== 1'b0 || bus.key_rdy !== 1'b0) early++;
        end
        chk("t41_no_early_err", early, 0);
        @(negedge clk);
        chk("t41_tmo_err", bus.err, 1);
        chk("t41_tmo_rdy", bus.key_rdy, 1);
        bus.alu_done = 1'b1; bus.alu_res = 16'd2;
        @(negedge clk);
        bus.alu_done = 1'b0; bus.alu_res = '0;
        repeat (2) @(negedge clk);
        chk("t41_late_err", bus.err, 1);
        chk("t41_late_disp", bus.disp, 0);

        // Reset in the middle of an operation.
        press(KEY_CLR);
        press(4'd4); press(KEY_MUL); press(4'd5); press(KEY_EQ);
        for (int i = 0; i < 4 && bus.alu_start !== 1'b1; i++) @(negedge clk);
        chk("t42_start", bus.alu_start, 1);
        chk("t42_op_mul", bus.alu_op, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t42_rdy", bus.key_rdy, 1);
        chk("t42_start_lo", bus.alu_start, 0);
        chk("t42_op", bus.alu_op, 0);
        chk("t42_opa", bus.opa, 0);
        chk("t42_opb", bus.opb, 0);
        chk("t42_disp", bus.disp, 0);
        chk("t42_err", bus.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        s0 = starts;
        bus.alu_done = 1'b1; bus.alu_res = 16'd20;
        @(negedge clk);
        bus.alu_done = 1'b0; bus.alu_res = '0;
        repeat (2) @(negedge clk);
        chk("t42_stale_disp", bus.disp, 0);
        chk("t42_stale_err", bus.err, 0);
        chk("t42_stale_rdy", bus.key_rdy, 1);
        press(4'd6);
        chk("t42_alive", bus.disp, 6);
        chk("t42_no_start", starts - s0, 0);

        // Random chains evaluated left to right.
        for (int it = 0; it < 25; it++) begin
            nops = $urandom_range(1, 3);
            for (int j = 0; j < 4; j++) vals[j] = $urandom_range(0, 120);
            for (int j = 0; j < 3; j++) ops[j] = 2'($urandom_range(0, 2));
            dead = 1'b0;
            press(KEY_CLR);
            type_num(vals[0]);
            chk("rnd_entry", bus.disp, vals[0]);
            press(opkey(ops[0]));
            acc = vals[0];
            type_num(vals[1]);
            for (int j = 1; j < nops && !dead; j++) begin
                press(opkey(ops[j]));
                serve(acc, vals[j], ops[j-1], $urandom_range(1, 5), "rnd_chain");
                acc = alu_true(acc, vals[j], ops[j-1]);
                if (acc < 0 || acc > MAXV) begin
                    dead = 1'b1;
                    chk("rnd_chain_err", bus.err, 1);
                end else begin
                    chk("rnd_chain_disp", bus.disp, acc[31:0]);
                    type_num(vals[j+1]);
                end
            end
            if (!dead) begin
                press(KEY_EQ);
                serve(acc, vals[nops], ops[nops-1], $urandom_range(1, 5), "rnd_eq");
                acc = alu_true(acc, vals[nops], ops[nops-1]);
                if (acc < 0 || acc > MAXV) begin
                    chk("rnd_final_err", bus.err, 1);
                    chk("rnd_final_disp0", bus.disp, 0);
                end else begin
                    chk("rnd_final_err", bus.err, 0);
                    chk("rnd_final_disp", bus.disp, acc[31:0]);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
